// File: rtl/vga_draw_pkg.sv
/*------------------------------------------------------------------------------
 * Module      : vga_draw_pkg
 * Description : Shared constants, state encoding and clip helper for the
 *               frame-buffer drawers.
 * Revision    : 1.0 - initial release
 *----------------------------------------------------------------------------*/
`default_nettype none

package vga_draw_pkg;

  localparam int SCREEN_W_DEF = 160;
  localparam int SCREEN_H_DEF = 120;
  localparam int COLOR_W_DEF  = 3;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_LOAD = 2'd1;
  localparam state_t ST_PLOT = 2'd2;
  localparam state_t ST_DONE = 2'd3;

  // Visible extent of a span starting at origin, clipped at the screen edge.
  function automatic int unsigned clip_extent(input int unsigned origin,
                                              input int unsigned size,
                                              input int unsigned limit);
    int unsigned result;
    if (origin >= limit) begin
      result = 0;
    end else if (size < (limit - origin)) begin
      result = size;
    end else begin
      result = limit - origin;
    end
    return result;
  endfunction

endpackage

`default_nettype wire

// File: rtl/xy_scan_counter.sv
/*------------------------------------------------------------------------------
 * Module      : xy_scan_counter
 * Description : Row-major 2D offset counter, x fastest, with last-pixel flag.
 * Revision    : 1.0 - initial release
 *----------------------------------------------------------------------------*/
`default_nettype none

module xy_scan_counter #(
  parameter int SIZE_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              advance,
  input  logic [SIZE_W-1:0] w_eff,
  input  logic [SIZE_W-1:0] h_eff,
  output logic [SIZE_W-1:0] x_off,
  output logic [SIZE_W-1:0] y_off,
  output logic              last
);

  logic [SIZE_W-1:0] x_off_q, x_off_d;
  logic [SIZE_W-1:0] y_off_q, y_off_d;
  logic              w_x_end;

  assign w_x_end = (x_off_q == (w_eff - SIZE_W'(1)));

  always_comb begin
    x_off_d = x_off_q;
    y_off_d = y_off_q;
    if (clear) begin
      x_off_d = '0;
      y_off_d = '0;
    end else if (advance) begin
      if (w_x_end) begin
        x_off_d = '0;
        y_off_d = y_off_q + SIZE_W'(1);
      end else begin
        x_off_d = x_off_q + SIZE_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      x_off_q <= '0;
      y_off_q <= '0;
    end else begin
      x_off_q <= x_off_d;
      y_off_q <= y_off_d;
    end
  end

  assign x_off = x_off_q;
  assign y_off = y_off_q;
  assign last  = w_x_end && (y_off_q == (h_eff - SIZE_W'(1)));

endmodule

`default_nettype wire

// File: rtl/vga_rect_filler.sv
/*------------------------------------------------------------------------------
 * Module      : vga_rect_filler
 * Description : Clipped rectangle / full-screen clear plotter with
 *               plot_ready backpressure toward the frame-buffer write port.
 * Revision    : 1.0 - initial release
 *----------------------------------------------------------------------------*/
`default_nettype none

module vga_rect_filler
  import vga_draw_pkg::*;
#(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF,
  parameter int COLOR_W  = COLOR_W_DEF,
  parameter int SIZE_W   = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               mode,
  input  logic [X_W-1:0]     x0,
  input  logic [Y_W-1:0]     y0,
  input  logic [SIZE_W-1:0]  rect_w,
  input  logic [SIZE_W-1:0]  rect_h,
  input  logic [COLOR_W-1:0] color_in,
  input  logic               plot_ready,
  output logic               busy,
  output logic               plot,
  output logic [X_W-1:0]     X,
  output logic [Y_W-1:0]     Y,
  output logic [COLOR_W-1:0] color_out,
  output logic               done
);

  state_t             state_q, state_d;
  logic               mode_q, mode_d;
  logic [X_W-1:0]     x_base_q, x_base_d;
  logic [Y_W-1:0]     y_base_q, y_base_d;
  logic [SIZE_W-1:0]  w_req_q, w_req_d;
  logic [SIZE_W-1:0]  h_req_q, h_req_d;
  logic [SIZE_W-1:0]  w_eff_q, w_eff_d;
  logic [SIZE_W-1:0]  h_eff_q, h_eff_d;
  logic [COLOR_W-1:0] color_q, color_d;

  logic [SIZE_W-1:0]  w_calc, h_calc;
  logic [SIZE_W-1:0]  x_off, y_off;
  logic               scan_last;
  logic               scan_clear, scan_advance;

  // Clear mode ignores the captured origin/size entirely.
  assign w_calc = mode_q ? SIZE_W'(SCREEN_W)
                         : SIZE_W'(clip_extent(32'(x_base_q), 32'(w_req_q), 32'(SCREEN_W)));
  assign h_calc = mode_q ? SIZE_W'(SCREEN_H)
                         : SIZE_W'(clip_extent(32'(y_base_q), 32'(h_req_q), 32'(SCREEN_H)));

  assign scan_clear   = (state_q == ST_LOAD);
  assign scan_advance = (state_q == ST_PLOT) && plot_ready;

  xy_scan_counter #(
    .SIZE_W (SIZE_W)
  ) u_scan (
    .clock   (clock),
    .reset   (reset),
    .clear   (scan_clear),
    .advance (scan_advance),
    .w_eff   (w_eff_q),
    .h_eff   (h_eff_q),
    .x_off   (x_off),
    .y_off   (y_off),
    .last    (scan_last)
  );

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    x_base_d = x_base_q;
    y_base_d = y_base_q;
    w_req_d  = w_req_q;
    h_req_d  = h_req_q;
    w_eff_d  = w_eff_q;
    h_eff_d  = h_eff_q;
    color_d  = color_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d   = mode;
          x_base_d = x0;
          y_base_d = y0;
          w_req_d  = rect_w;
          h_req_d  = rect_h;
          color_d  = color_in;
          state_d  = ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_eff_d = w_calc;
        h_eff_d = h_calc;
        if (mode_q) begin
          x_base_d = '0;
          y_base_d = '0;
        end
        state_d = ((w_calc == '0) || (h_calc == '0)) ? ST_DONE : ST_PLOT;
      end
      ST_PLOT: begin
        if (plot_ready && scan_last) begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      mode_q   <= 1'b0;
      x_base_q <= '0;
      y_base_q <= '0;
      w_req_q  <= '0;
      h_req_q  <= '0;
      w_eff_q  <= '0;
      h_eff_q  <= '0;
      color_q  <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      x_base_q <= x_base_d;
      y_base_q <= y_base_d;
      w_req_q  <= w_req_d;
      h_req_q  <= h_req_d;
      w_eff_q  <= w_eff_d;
      h_eff_q  <= h_eff_d;
      color_q  <= color_d;
    end
  end

  // Outputs decode registered state only; clipping keeps the sums on screen.
  assign busy      = (state_q != ST_IDLE);
  assign plot      = (state_q == ST_PLOT);
  assign done      = (state_q == ST_DONE);
  assign X         = x_base_q + X_W'(x_off);
  assign Y         = y_base_q + Y_W'(y_off);
  assign color_out = color_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_rect_filler.sv
/*------------------------------------------------------------------------------
 * Module      : tb_vga_rect_filler
 * Description : Directed self-checking bench for vga_rect_filler.
 * Revision    : 1.0 - initial release
 *----------------------------------------------------------------------------*/
`default_nettype none

module tb_vga_rect_filler;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic       mode;
  logic [7:0] x0;
  logic [6:0] y0;
  logic [7:0] rect_w;
  logic [7:0] rect_h;
  logic [2:0] color_in;
  logic       plot_ready;
  logic       busy;
  logic       plot;
  logic [7:0] X;
  logic [6:0] Y;
  logic [2:0] color_out;
  logic       done;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  vga_rect_filler dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .mode       (mode),
    .x0         (x0),
    .y0         (y0),
    .rect_w     (rect_w),
    .rect_h     (rect_h),
    .color_in   (color_in),
    .plot_ready (plot_ready),
    .busy       (busy),
    .plot       (plot),
    .X          (X),
    .Y          (Y),
    .color_out  (color_out),
    .done       (done)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Issues one request and checks every cycle against hand-computed extents.
  // rdy_pat bit k drives plot_ready in cycle k+2; beyond bit 31 it is 1.
  task automatic do_req(input string tag, input logic m, input int rx, input int ry,
                        input int rw, input int rh, input int col,
                        input int ebx, input int eby, input int ew, input int eh,
                        input logic [31:0] rdy_pat, input int exp_done);
    int n, p, cyc, limit;
    n = ew * eh;
    limit = exp_done + 10;
    @(posedge clock); #1;
    mode = m; x0 = 8'(rx); y0 = 7'(ry); rect_w = 8'(rw); rect_h = 8'(rh);
    color_in = 3'(col); start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    mode = ~m; x0 = 8'($urandom); y0 = 7'($urandom); rect_w = 8'($urandom);
    rect_h = 8'($urandom); color_in = 3'($urandom);
    cyc = 1;
    @(negedge clock);
    check_val({tag, "_load_busy"}, 32'(busy), 32'd1);
    check_val({tag, "_load_plot"}, 32'(plot), 32'd0);
    @(posedge clock); #1;
    cyc = 2;
    plot_ready = rdy_pat[0];
    p = 0;
    while (p < n && cyc < limit) begin
      @(negedge clock);
      check_val({tag, "_plot"}, 32'(plot), 32'd1);
      check_val({tag, "_x"}, 32'(X), 32'(ebx + (p % ew)));
      check_val({tag, "_y"}, 32'(Y), 32'(eby + (p / ew)));
      check_val({tag, "_color"}, 32'(color_out), 32'(col));
      if (plot_ready) p++;
      @(posedge clock); #1;
      cyc++;
      plot_ready = (cyc - 2 < 32) ? rdy_pat[cyc - 2] : 1'b1;
    end
    plot_ready = 1'b1;
    @(negedge clock);
    check_val({tag, "_done_cycle"}, 32'(cyc), 32'(exp_done));
    check_val({tag, "_done"}, 32'(done), 32'd1);
    check_val({tag, "_done_plot"}, 32'(plot), 32'd0);
    check_val({tag, "_done_busy"}, 32'(busy), 32'd1);
    @(posedge clock); #1;
    @(negedge clock);
    check_val({tag, "_idle_done"}, 32'(done), 32'd0);
    check_val({tag, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mode = 1'b0; x0 = '0; y0 = '0;
    rect_w = '0; rect_h = '0; color_in = '0; plot_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_plot", 32'(plot), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_x", 32'(X), 32'd0);
    check_val("rst_y", 32'(Y), 32'd0);
    check_val("rst_color", 32'(color_out), 32'd0);

    do_req("rect",  1'b0, 10, 20, 4, 3, 5, 10, 20, 4, 3, 32'hFFFF_FFFF, 14);
    do_req("clip",  1'b0, 158, 118, 5, 5, 2, 158, 118, 2, 2, 32'hFFFF_FFFF, 6);
    do_req("clipy", 1'b0, 7, 119, 1, 3, 4, 7, 119, 1, 1, 32'hFFFF_FFFF, 3);
    do_req("zerow", 1'b0, 5, 5, 0, 3, 1, 5, 5, 0, 3, 32'hFFFF_FFFF, 2);
    do_req("offx",  1'b0, 170, 5, 4, 4, 1, 170, 5, 0, 4, 32'hFFFF_FFFF, 2);
    do_req("bp",    1'b0, 30, 40, 2, 2, 6, 30, 40, 2, 2, 32'hFFFF_FFE9, 9);
    do_req("clear", 1'b1, 200, 100, 3, 3, 0, 0, 0, 160, 120, 32'hFFFF_FFFF, 19202);

    // Abandon a 4x4 draw part-way through.
    @(posedge clock); #1;
    mode = 1'b0; x0 = 8'd50; y0 = 7'd60; rect_w = 8'd4; rect_h = 8'd4;
    color_in = 3'd7; start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    @(negedge clock);
    check_val("mid_plot", 32'(plot), 32'd1);
    check_val("mid_x", 32'(X), 32'd51);
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    check_val("abort_plot", 32'(plot), 32'd0);
    check_val("abort_busy", 32'(busy), 32'd0);
    check_val("abort_done", 32'(done), 32'd0);
    @(posedge clock); #1;
    @(negedge clock);
    check_val("abort_no_done", 32'(done), 32'd0);
    do_req("after", 1'b0, 70, 80, 2, 2, 3, 70, 80, 2, 2, 32'hFFFF_FFFF, 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/vga_rect_filler.md
# vga_rect_filler

Parametrised rectangle plotter for the 160x120 raycaster frame path. It accepts a rectangle (origin, width, height, colour) or a full-screen clear request and emits one pixel write per accepted beat toward the frame-buffer write port. Generalises the fixed 4-pixel-wide column plotter with:
- arbitrary width and height
- screen-edge clipping
- a clear mode
- plot_ready backpressure so it can share the frame-buffer port with other drawers.

## Interface
Parameters:
- X_W, 8, X coordinate width
- Y_W, 7, Y coordinate width
- SCREEN_W, 160, visible columns
- SCREEN_H, 120, visible rows
- COLOR_W, 3, colour width
- SIZE_W, 8, width/height request field width

Ports:
- clock  in  1  single system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  request pulse; sampled only in IDLE
- mode  in  1  0 = rectangle, 1 = clear screen (origin/size ignored)
- x0  in  X_W  left column of rectangle
- y0  in  Y_W  top row of rectangle
- rect_w  in  SIZE_W  width in pixels
- rect_h  in  SIZE_W  height in pixels
- color_in  in  COLOR_W  fill colour
- plot_ready  in  1  frame-buffer port accepts the current pixel
- busy  out  1  high from the cycle after start acceptance until returning to IDLE
- plot  out  1  pixel valid (frame-buffer wren)
- X  out  X_W  pixel column
- Y  out  Y_W  pixel row
- color_out  out  COLOR_W  captured colour
- done  out  1  one-cycle pulse at completion

## Operation
- States: IDLE -> LOAD -> PLOT -> DONE -> IDLE.
- IDLE: busy=0, plot=0. If start=1, capture mode, x0, y0, rect_w, rect_h, color_in; go to LOAD.
- LOAD: compute clipped extents.
  - Rectangle: w_eff = 0 if x0 >= SCREEN_W, else min(rect_w, SCREEN_W-x0). h_eff likewise against SCREEN_H.
  - Clear: origin (0,0), w_eff=SCREEN_W, h_eff=SCREEN_H.
  - If w_eff=0 or h_eff=0, go to DONE. Otherwise go to PLOT with offsets (0,0).
- PLOT: plot=1, X=x_base+x_off, Y=y_base+y_off, color_out=captured colour.
  - A beat is accepted when plot and plot_ready are both 1. Only then does the scan advance.
  - Advance order is row-major, x fastest: x_off wraps from w_eff-1 to 0 and increments y_off.
  - When the last pixel (x_off=w_eff-1, y_off=h_eff-1) is accepted, go to DONE.
  - While plot_ready=0: X, Y, color_out and plot hold steady.
- DONE: done=1, plot=0, busy=1 for one cycle; then IDLE.
- start is ignored in LOAD, PLOT and DONE. It is never queued.
- Arithmetic: offsets are SIZE_W wide and sums are truncated to X_W/Y_W. Clipping guarantees no overflow, so X<SCREEN_W and Y<SCREEN_H always hold.
- Inputs may change after acceptance without affecting the operation in flight.

## Timing
- Reset values: busy=0, plot=0, done=0, X=0, Y=0, color_out=0; state=IDLE; offsets and captured registers 0.
- Reset asserted in any state returns to IDLE on the next edge with no done pulse. A partially drawn rectangle is abandoned.
- All outputs are Moore outputs driven from registers; no combinational path from inputs to outputs.
- start at edge 0 gives:
  - LOAD in cycle 1, busy=1
  - first pixel presented in cycle 2
  - with plot_ready held high, N=w_eff*h_eff pixels in cycles 2..N+1
  - done in cycle N+2
  - IDLE in cycle N+3, where a new start is accepted
- Zero-area request: done in cycle 2, no plot.
- Each cycle plot_ready=0 while plot=1 adds exactly one cycle of latency.

## Structure
- Shared package vga_draw_pkg:
  - state encoding localparams
  - SCREEN_W/SCREEN_H defaults
  - colour width constant
  - used by all frame-buffer drawers
- One sub-module, xy_scan_counter, a 2D offset counter:
  - inputs: clear, advance, w_eff, h_eff
  - outputs: x_off, y_off, last
  - instantiated once; the FSM and clip logic stay in vga_rect_filler.

## Test plan
- Rectangle x0=10, y0=20, w=4, h=3, colour 5, plot_ready=1 -> 12 beats (10..13, 20..22) in row-major order, colour 5; done at cycle 14.
- Clip: x0=158, y0=118, w=5, h=5 -> exactly 4 pixels (158,118), (159,118), (158,119), (159,119); then done.
- Zero/off-screen: w=0, and separately x0=170 -> no plot; done pulse at cycle 2.
- Backpressure: w=2, h=2 with plot_ready toggling 1,0,0,1,0,1,1 -> outputs hold while low; each pixel emitted exactly once; done 3 cycles later than the unstalled case.
- Clear mode, colour 0 -> 19200 beats covering (0,0)..(159,119); the second beat is (1,0); done after the last beat.
- Reset asserted mid-PLOT of a 4x4 request -> next cycle plot=0, busy=0, no done; a start two cycles later draws the new request from its first pixel.
